// File: rtl/straight_check_sequencer.sv
// straight_check_sequencer: drives the shared straight-line scanner in the
// order UP, LEFT, RIGHT, DOWN around a king square and collects rook/queen
// attackers into a check flag, first-attacker record and per-direction mask.
// Optional build macro: CHECK_EARLY_EXIT_EN stops scanning after the first
// attacker is sampled and finishes on the next cycle.
module straight_check_sequencer #(
  parameter int         SCAN_LATENCY = 1,
  parameter logic [2:0] ROOK_CODE    = 3'd4,
  parameter logic [2:0] QUEEN_CODE   = 3'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] king_pos,
  input  logic       king_color,
  output logic       busy,
  output logic       done,
  output logic       in_check,
  output logic [5:0] attacker_pos,
  output logic [1:0] attacker_dir,
  output logic [3:0] attack_mask,
  output logic       scan_req,
  output logic [5:0] scan_pos,
  output logic [1:0] scan_dir,
  input  logic [5:0] scan_nearest_pos,
  input  logic [3:0] scan_nearest_piece
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(SCAN_LATENCY - 1);

  state_t     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] kpos_q, kpos_d;
  logic       kcol_q, kcol_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       in_check_q, in_check_d;
  logic [5:0] attacker_pos_q, attacker_pos_d;
  logic [1:0] attacker_dir_q, attacker_dir_d;
  logic [3:0] attack_mask_q, attack_mask_d;
  logic       scan_req_q, scan_req_d;
  logic [5:0] scan_pos_q, scan_pos_d;
  logic [1:0] scan_dir_q, scan_dir_d;
  logic       hit;

  // A direction is skipped when the king already sits on that board edge.
  function automatic logic is_skip(input logic [1:0] d, input logic [5:0] p);
    case (d)
      2'd0:    is_skip = (p[2:0] == 3'd0);
      2'd1:    is_skip = (p[5:3] == 3'd0);
      2'd2:    is_skip = (p[5:3] == 3'd7);
      default: is_skip = (p[2:0] == 3'd7);
    endcase
  endfunction

  // Classify the scanner result: enemy rook or queen that is not the king itself.
  always_comb begin
    hit = ((scan_nearest_piece[2:0] == ROOK_CODE) || (scan_nearest_piece[2:0] == QUEEN_CODE)) &&
          (scan_nearest_piece[3] != kcol_q) && (scan_nearest_pos != kpos_q);
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    cnt_d          = cnt_q;
    kpos_d         = kpos_q;
    kcol_d         = kcol_q;
    in_check_d     = in_check_q;
    attacker_pos_d = attacker_pos_q;
    attacker_dir_d = attacker_dir_q;
    attack_mask_d  = attack_mask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kpos_d         = king_pos;
          kcol_d         = king_color;
          in_check_d     = 1'b0;
          attacker_pos_d = 6'd0;
          attacker_dir_d = 2'd0;
          attack_mask_d  = 4'd0;
          dir_d          = 2'd0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (is_skip(dir_q, kpos_q)) begin
          if (dir_q == 2'd3) begin
            state_d = DONE;
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end else begin
          cnt_d   = 2'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          if (hit) begin
            attack_mask_d[dir_q] = 1'b1;
            if (!in_check_q) begin
              in_check_d     = 1'b1;
              attacker_pos_d = scan_nearest_pos;
              attacker_dir_d = dir_q;
            end
          end
          if (dir_q == 2'd3) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            dir_d   = dir_q + 2'd1;
          end
`ifdef CHECK_EARLY_EXIT_EN
          if (hit) begin
            state_d = DONE;
          end
`else
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    scan_req_d = (state_d == ISSUE) && !is_skip(dir_d, kpos_d);
    scan_dir_d = scan_req_d ? dir_d : scan_dir_q;
    scan_pos_d = scan_req_d ? kpos_d : scan_pos_q;
    busy_d     = (state_d == ISSUE) || (state_d == WAIT);
    done_d     = (state_d == DONE);
  end

  // State and registered outputs; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dir_q          <= 2'd0;
      cnt_q          <= 2'd0;
      kpos_q         <= 6'd0;
      kcol_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      in_check_q     <= 1'b0;
      attacker_pos_q <= 6'd0;
      attacker_dir_q <= 2'd0;
      attack_mask_q  <= 4'd0;
      scan_req_q     <= 1'b0;
      scan_pos_q     <= 6'd0;
      scan_dir_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      cnt_q          <= cnt_d;
      kpos_q         <= kpos_d;
      kcol_q         <= kcol_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      in_check_q     <= in_check_d;
      attacker_pos_q <= attacker_pos_d;
      attacker_dir_q <= attacker_dir_d;
      attack_mask_q  <= attack_mask_d;
      scan_req_q     <= scan_req_d;
      scan_pos_q     <= scan_pos_d;
      scan_dir_q     <= scan_dir_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign in_check     = in_check_q;
  assign attacker_pos = attacker_pos_q;
  assign attacker_dir = attacker_dir_q;
  assign attack_mask  = attack_mask_q;
  assign scan_req     = scan_req_q;
  assign scan_pos     = scan_pos_q;
  assign scan_dir     = scan_dir_q;

endmodule

// File: tb/tb_straight_check_sequencer.sv
// Scoreboard bench for straight_check_sequencer: a task-level model predicts
// every scan request and the final result; a monitor compares at negedge.
module tb_straight_check_sequencer;

  localparam int L = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] king_pos = 6'd0;
  logic       king_color = 1'b0;
  logic       busy, done, in_check, scan_req;
  logic [5:0] attacker_pos, scan_pos;
  logic [1:0] attacker_dir, scan_dir;
  logic [3:0] attack_mask;
  logic [5:0] scan_nearest_pos = 6'd0;
  logic [3:0] scan_nearest_piece = 4'd0;

  straight_check_sequencer #(.SCAN_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .king_pos(king_pos), .king_color(king_color),
    .busy(busy), .done(done), .in_check(in_check), .attacker_pos(attacker_pos),
    .attacker_dir(attacker_dir), .attack_mask(attack_mask), .scan_req(scan_req),
    .scan_pos(scan_pos), .scan_dir(scan_dir), .scan_nearest_pos(scan_nearest_pos),
    .scan_nearest_piece(scan_nearest_piece)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [1:0] d; logic [5:0] p; } req_t;
  typedef struct { int c; logic ic; logic [5:0] ap; logic [1:0] ad; logic [3:0] m; } done_t;
  req_t  exp_req[$];
  done_t exp_done[$];

  logic [5:0] bpos[4];
  logic [3:0] bpc[4];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: walk the directions and account cycle costs directly.
  task automatic model(input logic [5:0] kp, input logic kc, input int s);
    int t;
    int mask;
    bit found;
    done_t dn;
    req_t r;
    t = s + 1;
    mask = 0;
    found = 0;
    dn.ap = 0;
    dn.ad = 0;
    for (int d = 0; d < 4; d++) begin
      bit skip;
      bit att;
      int typ;
      case (d)
        0: skip = (kp % 8 == 0);
        1: skip = (kp / 8 == 0);
        2: skip = (kp / 8 == 7);
        default: skip = (kp % 8 == 7);
      endcase
      if (skip) begin
        t += 1;
        continue;
      end
      r.c = t; r.d = 2'(d); r.p = kp;
      exp_req.push_back(r);
      t += L + 1;
      typ = int'(bpc[d] & 4'h7);
      att = (typ == 4 || typ == 5) && (bpc[d][3] != kc) && (bpos[d] != kp);
      if (att) begin
        mask |= (1 << d);
        if (!found) begin
          found = 1;
          dn.ap = bpos[d];
          dn.ad = 2'(d);
        end
`ifdef CHECK_EARLY_EXIT_EN
        break;
`endif
      end
    end
    dn.c = t;
    dn.ic = found;
    dn.m = 4'(mask);
    exp_done.push_back(dn);
  endtask

  // Scanner stand-in: present the board entry for the requested direction.
  always @(negedge clk) begin
    if (!rst && scan_req) begin
      scan_nearest_pos = bpos[scan_dir];
      scan_nearest_piece = bpc[scan_dir];
    end
  end

  // Monitor: pop and compare whenever the DUT presents a request or a done.
  always @(negedge clk) begin
    if (!rst && scan_req) begin
      if (exp_req.size() == 0) begin
        chk("unexpected_scan_req", 1, 0);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        chk("req_cycle", cyc, r.c);
        chk("req_dir", int'(scan_dir), int'(r.d));
        chk("req_pos", int'(scan_pos), int'(r.p));
        chk("req_busy", int'(busy), 1);
      end
    end
    if (!rst && done) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        done_t dn;
        dn = exp_done.pop_front();
        chk("done_cycle", cyc, dn.c);
        chk("in_check", int'(in_check), int'(dn.ic));
        chk("attack_mask", int'(attack_mask), int'(dn.m));
        chk("done_busy", int'(busy), 0);
        if (dn.ic) begin
          chk("attacker_pos", int'(attacker_pos), int'(dn.ap));
          chk("attacker_dir", int'(attacker_dir), int'(dn.ad));
        end
      end
    end
  end

  task automatic set_board(input logic [5:0] kp);
    for (int d = 0; d < 4; d++) begin
      bpos[d] = kp;
      bpc[d] = 4'd0;
    end
  endtask

  task automatic run(input logic [5:0] kp, input logic kc, input int ign_off);
    int base;
    int s;
    @(posedge clk); #1;
    s = cyc;
    model(kp, kc, s);
    king_pos = kp;
    king_color = kc;
    start = 1'b1;
    base = done_cnt;
    for (int i = 1; i < 60; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base) break;
      start = (ign_off > 0 && i == ign_off);
      if (start) king_pos = 6'($urandom_range(0, 63));
    end
    start = 1'b0;
    if (done_cnt == base) begin
      chk("done_timeout", 0, 1);
      exp_req.delete();
      exp_done.delete();
    end
  endtask

  task automatic reset_test();
    int s;
    set_board(6'd27);
    @(posedge clk); #1;
    s = cyc;
    model(6'd27, 1'b0, s);
    king_pos = 6'd27;
    king_color = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    exp_req.delete();
    exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_scan_req", int'(scan_req), 0);
    chk("rst_mask", int'(attack_mask), 0);
    chk("rst_cycle_offset", cyc - s, 5);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_in_check", int'(in_check), 0);
    chk("reset_scan_req", int'(scan_req), 0);
    chk("reset_mask", int'(attack_mask), 0);
    chk("reset_scan_pos", int'(scan_pos), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty board
    set_board(6'd27);
    run(6'd27, 1'b0, 0);
    // Enemy rook to the right
    set_board(6'd27);
    bpos[2] = 6'd43; bpc[2] = 4'b1100;
    run(6'd27, 1'b0, 0);
    // Corner: UP and LEFT skipped
    set_board(6'd0);
    run(6'd0, 1'b0, 0);
    // Opposite corner: RIGHT and DOWN skipped, rook on UP
    set_board(6'd63);
    bpos[0] = 6'd60; bpc[0] = 4'b1100;
    run(6'd63, 1'b0, 0);
    // Non-attackers and self-hit guard
    set_board(6'd27);
    bpos[0] = 6'd26; bpc[0] = 4'b0101;
    bpos[1] = 6'd19; bpc[1] = 4'b1011;
    bpos[2] = 6'd27; bpc[2] = 4'b1100;
    run(6'd27, 1'b0, 0);
    // Two attackers
    set_board(6'd27);
    bpos[0] = 6'd26; bpc[0] = 4'b1101;
    bpos[3] = 6'd31; bpc[3] = 4'b1100;
    run(6'd27, 1'b0, 0);
    // Black king, white queen on LEFT
    set_board(6'd27);
    bpos[1] = 6'd11; bpc[1] = 4'b0101;
    run(6'd27, 1'b1, 0);

    // Reset mid-scan, then start accepted right after, with a start ignored while busy
    reset_test();
    set_board(6'd27);
    bpos[2] = 6'd51; bpc[2] = 4'b1101;
    run(6'd27, 1'b0, 8);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      logic [5:0] kp;
      logic kc;
      kp = 6'($urandom_range(0, 63));
      kc = 1'($urandom_range(0, 1));
      for (int d = 0; d < 4; d++) begin
        case ($urandom_range(0, 3))
          0: bpc[d] = {1'($urandom_range(0, 1)), 3'd4};
          1: bpc[d] = {1'($urandom_range(0, 1)), 3'd5};
          2: bpc[d] = 4'd0;
          default: bpc[d] = 4'($urandom_range(0, 15));
        endcase
        bpos[d] = ($urandom_range(0, 5) == 0) ? kp : 6'($urandom_range(0, 63));
      end
      run(kp, kc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
